// File: rtl/afifo_pkg.sv
// Shared types for the async FIFO read-side logic.
// Output buffer occupancy states and beat counter sizing.
package afifo_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  // A beat counter always gets at least one bit, even for single-beat packets
  function automatic int beat_w(input int pkt_len);
    return $clog2(pkt_len > 1 ? pkt_len : 2);
  endfunction

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry registered valid/ready buffer.
// The head slot always drives the output; the tail only fills under back-pressure.
module skid_buffer2
  import afifo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output buf_state_e       state
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             pop;

  assign out_valid = (state_q != BUF_EMPTY);
  assign out_data  = head_q;
  assign state     = state_q;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          head_d  = push_data;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          tail_d  = push_data;
          state_d = BUF_FULL;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side drain: pops the FWFT FIFO into a 2-entry buffer
// and frames the resulting stream into fixed-length packets.
module fifo_stream_reader
  import afifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int PKT_LEN   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 read_clk,
  input  logic                 read_reset,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_read_data,
  output logic                 fifo_read_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [CNT_WIDTH-1:0] pop_count
);

  localparam int BW = beat_w(PKT_LEN);

  buf_state_e           buf_state;
  logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0] pop_count_q, pop_count_d;
  logic                 last_beat;
  logic                 pop;

  // Pop decision uses only registered occupancy, keeping out_ready off this path
  assign fifo_read_en = !read_reset && !fifo_empty
                        && (buf_state != BUF_FULL);

  skid_buffer2 #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk       (read_clk),
    .rst       (read_reset),
    .push      (fifo_read_en),
    .push_data (fifo_read_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .state     (buf_state)
  );

  assign pop       = out_valid && out_ready;
  assign last_beat = (beat_cnt_q == BW'(PKT_LEN - 1));
  assign out_last  = out_valid && last_beat;
  assign pop_count = pop_count_q;

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    pop_count_d = pop_count_q + CNT_WIDTH'(fifo_read_en);
    if (pop) begin
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge read_clk) begin
    if (read_reset) begin
      beat_cnt_q  <= '0;
      pop_count_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      pop_count_q <= pop_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader with a queue-backed FWFT FIFO model.
module tb_fifo_stream_reader;

  localparam int WIDTH   = 32;
  localparam int PKT_LEN = 4;
  localparam int CNT_W   = 4;

  logic             read_clk;
  logic             read_reset;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_read_data;
  logic             fifo_read_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [CNT_W-1:0] pop_count;

  fifo_stream_reader #(
    .WIDTH     (WIDTH),
    .PKT_LEN   (PKT_LEN),
    .CNT_WIDTH (CNT_W)
  ) dut (
    .read_clk       (read_clk),
    .read_reset     (read_reset),
    .fifo_empty     (fifo_empty),
    .fifo_read_data (fifo_read_data),
    .fifo_read_en   (fifo_read_en),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .pop_count      (pop_count)
  );

  initial read_clk = 1'b0;
  always #5 read_clk = ~read_clk;

  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beat = 0;
  int pcnt = 0;
  int pushes = 0;
  int acc = 0;
  int first_push = -1;
  int lat_idx = 0;
  bit lat_on = 0;
  bit gap = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    logic [WIDTH-1:0] e;
    fifo_empty     = (fq.size() == 0) || gap;
    fifo_read_data = (fq.size() != 0) ? fq[0] : '0;
    #1;
    if (read_reset) begin
      sb.delete();
      beat = 0;
      pcnt = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("data", out_data, e);
          chk("last", out_last, (beat == PKT_LEN - 1));
          beat = (beat == PKT_LEN - 1) ? 0 : beat + 1;
          if (lat_on) begin
            chk("latency", cyc, first_push + 1 + lat_idx);
            lat_idx++;
          end
        end
        acc++;
      end
      if (fifo_read_en) begin
        if (fq.size() == 0 || gap) begin
          chk("pop_while_empty", 1, 0);
        end else begin
          sb.push_back(fq.pop_front());
          pcnt++;
          pushes++;
          if (first_push < 0) first_push = cyc;
        end
      end
    end
    @(posedge read_clk);
    cyc++;
    @(negedge read_clk);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((fq.size() != 0 || sb.size() != 0) && n < max) begin
      cycle();
      n++;
    end
    chk("drain_timeout", (n >= max), 0);
    chk("sb_empty", sb.size(), 0);
  endtask

  task automatic do_reset();
    read_reset = 1'b1;
    cycle();
    read_reset = 1'b0;
  endtask

  initial begin
    read_reset     = 1'b1;
    out_ready      = 1'b0;
    fifo_empty     = 1'b0;
    fifo_read_data = '0;
    @(negedge read_clk);

    // Reset held with words waiting in the FIFO
    for (int i = 0; i < 8; i++) fq.push_back(32'hA000_0000 + i);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_read_en", fifo_read_en, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_pop_count", pop_count, 0);
      chk("rst_data", out_data, 0);
      chk("rst_last", out_last, 0);
    end

    // Back-to-back stream, ready held high
    read_reset = 1'b0;
    out_ready  = 1'b1;
    lat_on     = 1;
    first_push = -1;
    lat_idx    = 0;
    drain(30);
    lat_on = 0;
    chk("a_lat_beats", lat_idx, 8);
    chk("a_pop_count", pop_count, 8);

    // Long back-pressure fills the buffer
    do_reset();
    for (int i = 0; i < 4; i++) fq.push_back(32'hB000_0000 + i);
    out_ready = 1'b0;
    pushes    = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (out_valid) chk("b_hold", out_data, 32'hB000_0000);
    end
    chk("b_stall_pops", pushes, 2);
    chk("b_stall_count", pop_count, 2);
    chk("b_full_read_en", fifo_read_en, 0);
    chk("b_valid", out_valid, 1);
    out_ready = 1'b1;
    drain(30);
    chk("b_pop_count", pop_count, 4);

    // Toggling ready with FIFO gaps
    do_reset();
    for (int i = 0; i < 12; i++) fq.push_back(32'hC000_0000 + i);
    acc = 0;
    for (int i = 0; i < 80 && (fq.size() != 0 || sb.size() != 0); i++) begin
      out_ready = (i % 2 == 0);
      gap       = (i % 5 == 3);
      cycle();
    end
    gap = 0;
    chk("c_accepted", acc, 12);
    chk("c_sb_empty", sb.size(), 0);
    chk("c_pop_count", pop_count, 12);

    // Reset mid-packet while the buffer is full
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) fq.push_back(32'hD000_0000 + i);
    for (int n = 0; beat != 2 && n < 40; n++) cycle();
    chk("d_mid_beat", beat, 2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("d_full_read_en", fifo_read_en, 0);
    chk("d_full_valid", out_valid, 1);
    read_reset = 1'b1;
    cycle();
    read_reset = 1'b0;
    chk("d_rst_valid", out_valid, 0);
    chk("d_rst_count", pop_count, 0);
    out_ready = 1'b1;
    drain(40);

    // Pop counter wrap at 2^CNT_W
    do_reset();
    for (int i = 0; i < 17; i++) fq.push_back(32'hE000_0000 + i);
    drain(40);
    chk("e_wrap_count", pop_count, (pcnt % (1 << CNT_W)));
    chk("e_wrap_value", pop_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
